// File: rtl/fpu_fpr_sb_pkg.sv
// Shared types and default sizes for the FPU register file with busy scoreboard.
package fpu_fpr_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } fpr_state_e;

  localparam int FPR_FPLEN_DEF = 16;
  localparam int FPR_NREGS_DEF = 32;

endpackage

// File: rtl/fpu_fpr_sb_if.sv
// Read/write/scoreboard bus of the FPU register file. The master side is the
// decode/issue stage plus the execution units; the register file is the slave.
interface fpu_fpr_sb_if
  import fpu_fpr_pkg::*;
#(
  parameter int FPLEN = FPR_FPLEN_DEF,
  parameter int NREGS = FPR_NREGS_DEF,
  parameter int NRD   = 3,
  localparam int AW   = $clog2(NREGS)
);

  logic                   clr_req;
  logic                   ready;
  logic [NRD-1:0]         rden;
  logic [NRD*AW-1:0]      raddr;
  logic [NRD*FPLEN-1:0]   rdata;
  logic [NRD-1:0]         rbusy;
  logic                   wen0;
  logic [AW-1:0]          waddr0;
  logic [FPLEN-1:0]       wd0;
  logic                   wen1;
  logic [AW-1:0]          waddr1;
  logic [FPLEN-1:0]       wd1;
  logic                   sb_set;
  logic [AW-1:0]          sb_addr;
  logic                   wcoll;

  modport master (
    output clr_req, rden, raddr, wen0, waddr0, wd0, wen1, waddr1, wd1, sb_set, sb_addr,
    input  ready, rdata, rbusy, wcoll
  );

  modport slave (
    input  clr_req, rden, raddr, wen0, waddr0, wd0, wen1, waddr1, wd1, sb_set, sb_addr,
    output ready, rdata, rbusy, wcoll
  );

endinterface

// File: rtl/fpu_fpr_sb_rdport.sv
// One combinational read port: address mux with rden/ready gating.
// FPU_FPR_BYPASS_EN adds same-cycle forwarding of active writes.
module fpu_fpr_rdport
  import fpu_fpr_pkg::*;
#(
  parameter int FPLEN = FPR_FPLEN_DEF,
  parameter int NREGS = FPR_NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             i_rden,
  input  logic             i_ready,
  input  logic [AW-1:0]    i_raddr,
  input  logic [FPLEN-1:0] i_mem [NREGS],
  input  logic [NREGS-1:0] i_busy,
`ifdef FPU_FPR_BYPASS_EN
  input  logic             i_wen0,
  input  logic [AW-1:0]    i_waddr0,
  input  logic [FPLEN-1:0] i_wd0,
  input  logic             i_wen1,
  input  logic [AW-1:0]    i_waddr1,
  input  logic [FPLEN-1:0] i_wd1,
  input  logic             i_sb_set,
  input  logic [AW-1:0]    i_sb_addr,
`endif
  output logic [FPLEN-1:0] o_rdata,
  output logic             o_rbusy
);

  logic [FPLEN-1:0] w_data;
  logic             w_busy;

  always_comb begin
    w_data = i_mem[i_raddr];
    w_busy = i_busy[i_raddr];
`ifdef FPU_FPR_BYPASS_EN
    // port 1 is checked last so it wins a same-address collision
    if (i_wen0 && (i_waddr0 == i_raddr)) w_data = i_wd0;
    if (i_wen1 && (i_waddr1 == i_raddr)) begin
      w_data = i_wd1;
      if (!(i_sb_set && (i_sb_addr == i_raddr))) w_busy = 1'b0;
    end
`endif
    o_rdata = (i_rden && i_ready) ? w_data : '0;
    o_rbusy = i_rden && i_ready && w_busy;
  end

endmodule

// File: rtl/fpu_fpr_sb.sv
// FPU register file: NREGS x FPLEN, NRD read ports, pipe + long-latency write
// ports, busy scoreboard and sequential clear engine. Option: FPU_FPR_BYPASS_EN.
//
//   state | meaning
//   CLEAR | zeroing register[r_cnt] each cycle; ports ignored, reads return 0
//   READY | normal read/write/scoreboard operation
module fpu_fpr_sb
  import fpu_fpr_pkg::*;
#(
  parameter int FPLEN = FPR_FPLEN_DEF,
  parameter int NREGS = FPR_NREGS_DEF,
  parameter int NRD   = 3,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic        clk,
  input  logic        rst,
  fpu_fpr_sb_if.slave bus
);

  fpr_state_e           r_state, w_state_nxt;
  logic [AW-1:0]        r_cnt, w_cnt_nxt;
  logic [FPLEN-1:0]     r_mem [NREGS];
  logic [NREGS-1:0]     r_busy;
  logic                 r_wcoll;
  logic                 w_ready;
  logic                 w_clr_we;
  logic                 w_wr_ok;
  logic                 w_coll;
  logic [NRD*FPLEN-1:0] w_rdata;
  logic [NRD-1:0]       w_rbusy;

  assign w_coll = bus.wen0 && bus.wen1 && (bus.waddr0 == bus.waddr1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    w_clr_we    = 1'b0;
    w_wr_ok     = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_we  = !rst;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == AW'(NREGS - 1)) w_state_nxt = READY;
      end
      READY: begin
        w_ready = 1'b1;
        if (bus.clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_wr_ok = !rst;
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= '0;
      r_wcoll <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wcoll <= w_wr_ok && w_coll;
      if (w_ready && bus.clr_req) begin
        r_busy <= '0;
      end else if (w_wr_ok) begin
        // set after clear so a same-address issue keeps the register busy
        if (bus.wen1)   r_busy[bus.waddr1] <= 1'b0;
        if (bus.sb_set) r_busy[bus.sb_addr] <= 1'b1;
      end
    end
  end

  // Storage has no reset; the clear engine is the only way contents get zeroed.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      if (bus.wen0 && !w_coll) r_mem[bus.waddr0] <= bus.wd0;
      if (bus.wen1)            r_mem[bus.waddr1] <= bus.wd1;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    fpu_fpr_rdport #(
      .FPLEN (FPLEN),
      .NREGS (NREGS)
    ) u_rdport (
      .i_rden    (bus.rden[gi]),
      .i_ready   (w_ready),
      .i_raddr   (bus.raddr[gi*AW +: AW]),
      .i_mem     (r_mem),
      .i_busy    (r_busy),
`ifdef FPU_FPR_BYPASS_EN
      .i_wen0    (w_wr_ok && bus.wen0),
      .i_waddr0  (bus.waddr0),
      .i_wd0     (bus.wd0),
      .i_wen1    (w_wr_ok && bus.wen1),
      .i_waddr1  (bus.waddr1),
      .i_wd1     (bus.wd1),
      .i_sb_set  (w_wr_ok && bus.sb_set),
      .i_sb_addr (bus.sb_addr),
`endif
      .o_rdata   (w_rdata[gi*FPLEN +: FPLEN]),
      .o_rbusy   (w_rbusy[gi])
    );
  end

  assign bus.ready = w_ready;
  assign bus.rdata = w_rdata;
  assign bus.rbusy = w_rbusy;
  assign bus.wcoll = r_wcoll;

endmodule

// File: tb/tb_fpu_fpr_sb.sv
// Scoreboard bench for fpu_fpr_sb: expected read results are queued as reads
// are driven and compared when sampled on the falling edge.
module tb_fpu_fpr_sb;

  localparam int FPLEN = 16;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  typedef struct {
    int          p;
    logic [15:0] d;
    logic        b;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_fpr_sb_if #(.FPLEN(FPLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  fpu_fpr_sb #(.FPLEN(FPLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int               errors = 0;
  int               checks = 0;
  rd_exp_t          q[$];
  logic [15:0]      m_mem [NREGS];
  logic [NREGS-1:0] m_busy;
  logic             m_ready;
  logic             m_wcoll;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.clr_req = 1'b0;
    bus.rden    = '0;
    bus.raddr   = '0;
    bus.wen0    = 1'b0;
    bus.waddr0  = '0;
    bus.wd0     = '0;
    bus.wen1    = 1'b0;
    bus.waddr1  = '0;
    bus.wd1     = '0;
    bus.sb_set  = 1'b0;
    bus.sb_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_data(int a);
    logic [15:0] d;
    if (!m_ready) return 16'h0000;
    d = m_mem[a];
`ifdef FPU_FPR_BYPASS_EN
    if (!bus.clr_req) begin
      if (bus.wen0 && (int'(bus.waddr0) == a)) d = bus.wd0;
      if (bus.wen1 && (int'(bus.waddr1) == a)) d = bus.wd1;
    end
`endif
    return d;
  endfunction

  function automatic logic exp_busy(int a);
    if (!m_ready) return 1'b0;
`ifdef FPU_FPR_BYPASS_EN
    if (!bus.clr_req && bus.wen1 && (int'(bus.waddr1) == a) &&
        !(bus.sb_set && (int'(bus.sb_addr) == a))) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic rd_push(input int p, input int a);
    rd_exp_t e;
    bus.rden[p] = 1'b1;
    bus.raddr[p*AW +: AW] = AW'(a);
    e.p = p;
    e.d = exp_data(a);
    e.b = exp_busy(a);
    q.push_back(e);
  endtask

  task automatic rd_push_off(input int p, input int a);
    rd_exp_t e;
    bus.rden[p] = 1'b0;
    bus.raddr[p*AW +: AW] = AW'(a);
    e.p = p;
    e.d = 16'h0000;
    e.b = 1'b0;
    q.push_back(e);
  endtask

  task automatic sample();
    rd_exp_t e;
    @(negedge clk);
    chk("ready", bus.ready, m_ready);
    chk("wcoll", bus.wcoll, m_wcoll);
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("rdata[%0d]", e.p), bus.rdata[e.p*FPLEN +: FPLEN], e.d);
      chk($sformatf("rbusy[%0d]", e.p), bus.rbusy[e.p], e.b);
    end
  endtask

  // Reference update for one clock edge, taken from the currently driven inputs.
  task automatic commit();
    logic same;
    if (m_ready) begin
      if (bus.clr_req) begin
        m_busy  = '0;
        m_ready = 1'b0;
        m_wcoll = 1'b0;
      end else begin
        same    = (bus.waddr0 == bus.waddr1);
        m_wcoll = bus.wen0 && bus.wen1 && same;
        if (bus.wen0 && !m_wcoll) m_mem[bus.waddr0] = bus.wd0;
        if (bus.wen1) begin
          m_mem[bus.waddr1]  = bus.wd1;
          m_busy[bus.waddr1] = 1'b0;
        end
        if (bus.sb_set) m_busy[bus.sb_addr] = 1'b1;
      end
    end else begin
      m_wcoll = 1'b0;
    end
  endtask

  task automatic cycle();
    sample();
    commit();
    tick();
    idle();
  endtask

  // Called right after the edge that entered CLEAR; leaves the bench at READY.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    bus.rden = '1;
    for (int p = 0; p < NRD; p++) bus.raddr[p*AW +: AW] = AW'(7 * p + 3);
    while (1) begin
      @(negedge clk);
      if (bus.ready === 1'b1) break;
      chk({tag, "_rdata"}, bus.rdata, 0);
      chk({tag, "_rbusy"}, bus.rbusy, 0);
      chk({tag, "_wcoll"}, bus.wcoll, 0);
      n++;
      if (n > 100) break;
    end
    chk({tag, "_len"}, n, NREGS);
    idle();
    for (int i = 0; i < NREGS; i++) m_mem[i] = 16'h0000;
    m_busy  = '0;
    m_ready = 1'b1;
    m_wcoll = 1'b0;
    tick();
  endtask

  task automatic read_all();
    for (int a = 0; a < NREGS; a += NRD) begin
      for (int p = 0; p < NRD; p++)
        if (a + p < NREGS) rd_push(p, a + p);
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    m_ready = 1'b0;
    m_wcoll = 1'b0;
    m_busy  = '0;
    for (int i = 0; i < NREGS; i++) m_mem[i] = 16'h0000;

    // reset, then the power-up clear
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_clear("rst_clr");
    rd_push(0, 0);
    rd_push(1, 17);
    rd_push(2, 31);
    cycle();

    // pipe write, visible next cycle
    bus.wen0 = 1'b1; bus.waddr0 = 5'd5; bus.wd0 = 16'h3F80;
    rd_push(0, 5);
    cycle();
    rd_push(0, 5);
    cycle();

    // scoreboard set/clear, set wins over same-address clear
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    cycle();
    rd_push(1, 9);
    cycle();
    bus.wen1 = 1'b1; bus.waddr1 = 5'd9; bus.wd1 = 16'h4000;
    rd_push(1, 9);
    cycle();
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    bus.wen1 = 1'b1; bus.waddr1 = 5'd9; bus.wd1 = 16'h5555;
    rd_push(1, 9);
    cycle();
    rd_push(2, 9);
    bus.wen0 = 1'b1; bus.waddr0 = 5'd9; bus.wd0 = 16'h6666;
    cycle();
    rd_push(0, 9);
    cycle();

    // write collision on addr 3, then a non-colliding dual write
    bus.wen0 = 1'b1; bus.waddr0 = 5'd3; bus.wd0 = 16'h1111;
    bus.wen1 = 1'b1; bus.waddr1 = 5'd3; bus.wd1 = 16'h2222;
    cycle();
    rd_push(0, 3);
    bus.wen0 = 1'b1; bus.waddr0 = 5'd4; bus.wd0 = 16'hAAAA;
    bus.wen1 = 1'b1; bus.waddr1 = 5'd6; bus.wd1 = 16'hBBBB;
    cycle();
    rd_push(0, 4);
    rd_push(1, 6);
    rd_push(2, 3);
    cycle();

    // fill every register, mark some busy, read all back
    for (int i = 0; i < NREGS; i++) begin
      bus.wen0 = 1'b1; bus.waddr0 = AW'(i); bus.wd0 = 16'($urandom_range(1, 16'hFFFF));
      if (i % 4 == 1) begin
        bus.sb_set = 1'b1; bus.sb_addr = AW'(i);
      end
      cycle();
    end
    read_all();

    // clear request: same-cycle write dropped, writes during CLEAR ignored
    bus.clr_req = 1'b1;
    bus.wen0 = 1'b1; bus.waddr0 = 5'd7; bus.wd0 = 16'hDEAD;
    rd_push(0, 7);
    cycle();
    bus.wen0 = 1'b1; bus.waddr0 = 5'd8; bus.wd0 = 16'hBEEF;
    bus.wen1 = 1'b1; bus.waddr1 = 5'd8; bus.wd1 = 16'hCAFE;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd8;
    wait_clear("req_clr");
    read_all();

    // reset in the middle of CLEAR restarts it
    bus.wen0 = 1'b1; bus.waddr0 = 5'd20; bus.wd0 = 16'h1234;
    cycle();
    bus.wen1 = 1'b1; bus.waddr1 = 5'd31; bus.wd1 = 16'h4321;
    cycle();
    bus.clr_req = 1'b1;
    cycle();
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear("rst_mid");
    read_all();

    // rden=0 forces zero data and busy
    bus.wen0 = 1'b1; bus.waddr0 = 5'd12; bus.wd0 = 16'h7777;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd12;
    cycle();
    rd_push_off(0, 12);
    rd_push(1, 12);
    rd_push_off(2, 12);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_fpr_sb.md
Name: fpu_fpr_sb

Overview:
- Parametrised successor to the FPU floating-point register file: NREGS x FPLEN storage, NRD combinational read ports, two write ports and a per-register busy scoreboard.
- Write port 0 takes single-cycle pipe writeback; write port 1 takes long-latency writeback (div/sqrt).
- Contents are cleared by a sequential clear engine after reset or on request, one register per cycle.
- Sits between the FPU decode/issue stage and the execution units.

Parameters:
- FPLEN, 16, data width of each register.
- NREGS, 32, register count; power of 2, minimum 2.
- AW, $clog2(NREGS), address width; derived, do not override.
- NRD, 3, number of read ports.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clr_req  in  1  request a full register clear; honoured only in READY.
- ready  out  1  high in READY; low during CLEAR.
- rden  in  NRD  per-port read enable.
- raddr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NRD*FPLEN  read data; port i occupies bits [i*FPLEN +: FPLEN].
- rbusy  out  NRD  busy bit of each addressed register; 0 when rden[i]=0.
- wen0, waddr0 [AW], wd0 [FPLEN]  in  pipe write port.
- wen1, waddr1 [AW], wd1 [FPLEN]  in  long-latency write port; also clears busy.
- sb_set  in  1  issue marks destination register busy.
- sb_addr  in  AW  destination address for sb_set.
- wcoll  out  1  registered pulse: wen0 and wen1 targeted the same address in the previous cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all busy bits 0, wcoll=0, clear counter=0, state=CLEAR, ready=0.
  - Register contents are not touched by rst directly; the clear engine zeroes them.
- FSM CLEAR:
  - each cycle writes 0 to register[cnt], then cnt++.
  - When cnt=NREGS-1, that register is written and the FSM goes to READY next cycle, so CLEAR lasts exactly NREGS cycles.
  - wen0, wen1, sb_set and clr_req are ignored; rdata=0 and rbusy=0 for all ports.
- FSM READY:
  - clr_req=1 -> CLEAR with cnt=0 and all busy bits cleared in the same edge.
  - Writes issued in that same cycle are dropped.
- rst asserted during CLEAR restarts CLEAR from cnt=0.
- Reads are combinational, 0-cycle latency:
  - rdata[i] = reg[raddr[i]] when rden[i]=1 and ready=1, else 0.
  - rbusy[i] follows the same gating.
- Writes become visible to reads in the cycle after the write edge.
- Write collision (wen0 and wen1 both set, waddr0==waddr1): port 1 data is stored, port 0 is dropped, and wcoll pulses high for one cycle.
- Scoreboard:
  - sb_set sets busy[sb_addr].
  - wen1 clears busy[waddr1].
  - If both hit the same address in one cycle, set wins (busy stays 1).
  - wen0 never changes busy.
- All out-of-range conditions are impossible by construction because NREGS is a power of 2.

Optional Feature:
- Macro FPU_FPR_BYPASS_EN.
- When defined, same-cycle write-to-read forwarding applies in READY. A read port whose address matches an active write returns that write data combinationally, with wd1 taking priority over wd0 on collision. rbusy[i] shows 0 when wen1 targets that address in the same cycle and no same-address sb_set is present.
- When undefined, there is no forwarding: reads return the stored value and writes appear next cycle.

Decomposition:
- Shared package fpu_fpr_pkg holds:
  - FSM state enum: CLEAR=1'b0, READY=1'b1.
  - Default FPLEN and NREGS constants.
- One sub-module, fpu_fpr_rdport: a single read port (mux, rden/ready gating, optional bypass), instantiated NRD times in a generate loop.

Test Plan:
- Reset then idle: ready=0 for exactly 32 cycles, then 1. Reading any address with rden=1 returns 16'h0000 and rbusy=0.
- After ready: wen0 to addr 5 with 16'h3F80. Next cycle raddr0=5 returns 16'h3F80; in the write cycle it returns the old value 16'h0000 (16'h3F80 with FPU_FPR_BYPASS_EN).
- sb_set addr 9, then rbusy=1 on a port reading 9. wen1 to addr 9 with 16'h4000 gives rbusy=0 and data 16'h4000 next cycle. sb_set(9) together with wen1(9) leaves rbusy=1.
- wen0 (16'h1111) and wen1 (16'h2222) both to addr 3: wcoll=1 next cycle only, and reg 3 reads 16'h2222.
- Load regs 0..31, then clr_req: ready drops for 32 cycles, all busy bits clear, and a write during CLEAR is ignored. After ready, every register reads 0.
- rst asserted at cnt=10 during CLEAR: CLEAR restarts and ready rises 32 cycles after rst deasserts. rden=0 on any port gives rdata=0 regardless of contents.
